// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule (W) generator
// Sliding 16-word window; emits one W[t] per step, cross-checked against the round counter.
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64,
  parameter bit CHECK_SYNC = 1'b1
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         load_i,
  input  logic [511:0] block_in_i,
  input  logic         step_i,
  input  logic         clear_i,
  input  logic [6:0]   round_idx_i,
  output logic [31:0]  w_out_o,
  output logic         w_valid_o,
  output logic [6:0]   t_idx_o,
  output logic         done_o,
  output logic         sync_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_e;

  localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [6:0]  t_idx_q, t_idx_d;
  logic        sync_err_q, sync_err_d;
  logic        is_active, adv;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign is_active = (state_q == S_ACTIVE);
  // The final word stays on w_out; the terminal step only moves the FSM to DONE.
  assign adv       = is_active && step_i && !load_i && (t_idx_q != LAST_T);

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (load_i) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (load_i) state_d = S_ACTIVE;
        else if (step_i && (t_idx_q == LAST_T)) state_d = S_DONE;
      end
      S_DONE: begin
        if (load_i) state_d = S_ACTIVE;
        else if (clear_i) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid_o = (state_q == S_ACTIVE);
    done_o    = (state_q == S_DONE);
  end

  always_comb begin
    win_d   = win_q;
    t_idx_d = t_idx_q;
    if (load_i) begin
      for (int i = 0; i < 16; i++) begin
        win_d[i] = block_in_i[511-32*i -: 32];
      end
      t_idx_d = 7'd0;
    end else if (adv) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
      t_idx_d   = t_idx_q + 7'd1;
    end
  end

  always_comb begin
    sync_err_d = sync_err_q;
    if (CHECK_SYNC && is_active && step_i && (round_idx_i != t_idx_q)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
      t_idx_q    <= 7'd0;
      sync_err_q <= 1'b0;
    end else begin
      win_q      <= win_d;
      t_idx_q    <= t_idx_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign w_out_o    = win_q[0];
  assign t_idx_o    = t_idx_q;
  assign sync_err_o = CHECK_SYNC ? sync_err_q : 1'b0;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
// Constant vectors for the "abc" block plus a reference W-expansion model for random blocks.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         n_rst;
  logic         load;
  logic [511:0] block_in;
  logic         step;
  logic         clear;
  logic [6:0]   round_idx;
  logic [31:0]  w_out;
  logic         w_valid;
  logic [6:0]   t_idx;
  logic         done;
  logic         sync_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] mw [0:63];
  logic [511:0] abc_blk;

  typedef struct {
    int          steps;
    logic [31:0] exp_w;
    logic [6:0]  exp_t;
  } vec_t;

  vec_t vecs [6];

  sha256_msg_schedule dut (
    .clk_i       (clk),
    .n_rst_i     (n_rst),
    .load_i      (load),
    .block_in_i  (block_in),
    .step_i      (step),
    .clear_i     (clear),
    .round_idx_i (round_idx),
    .w_out_o     (w_out),
    .w_valid_o   (w_valid),
    .t_idx_o     (t_idx),
    .done_o      (done),
    .sync_err_o  (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) mw[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [511:0] b);
    load = 1'b1; block_in = b;
    tick();
    load = 1'b0;
  endtask

  task automatic do_step(input logic [6:0] ridx);
    step = 1'b1; round_idx = ridx;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  task automatic run_block(input logic [511:0] b, input string tag);
    int gap;
    build_model(b);
    do_load(b);
    for (int t = 0; t < 64; t++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) tick();
      check({tag, " w"}, w_out, mw[t]);
      check({tag, " t"}, 32'(t_idx), 32'(t));
      do_step(7'(t));
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " valid"}, 32'(w_valid), 32'd0);
  endtask

  initial begin
    logic [511:0] b2;
    abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
    vecs[0]   = '{0,  32'h61626380, 7'd0};
    vecs[1]   = '{1,  32'h00000000, 7'd1};
    vecs[2]   = '{14, 32'h00000000, 7'd14};
    vecs[3]   = '{15, 32'h00000018, 7'd15};
    vecs[4]   = '{16, 32'h61626380, 7'd16};
    vecs[5]   = '{17, 32'h000F0000, 7'd17};

    n_rst = 1'b0; load = 1'b0; block_in = '0; step = 1'b0; clear = 1'b0; round_idx = '0;
    tick(); tick();
    n_rst = 1'b1;
    check("rst w_out", w_out, 32'd0);
    check("rst t_idx", 32'(t_idx), 32'd0);
    check("rst w_valid", 32'(w_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sync_err", 32'(sync_err), 32'd0);

    // IDLE ignores step, including a mismatched round_idx
    do_step(7'h55);
    check("idle step valid", 32'(w_valid), 32'd0);
    check("idle step sync", 32'(sync_err), 32'd0);

    // Load and hold with no step
    do_load(abc_blk);
    for (int c = 0; c < 10; c++) begin
      check("hold w", w_out, 32'h61626380);
      check("hold t", 32'(t_idx), 32'd0);
      check("hold valid", 32'(w_valid), 32'd1);
      tick();
    end

    // Table of constant "abc" schedule words
    for (int v = 0; v < 6; v++) begin
      do_load(abc_blk);
      for (int s = 0; s < vecs[v].steps; s++) do_step(7'(s));
      check($sformatf("vec%0d w", v), w_out, vecs[v].exp_w);
      check($sformatf("vec%0d t", v), 32'(t_idx), 32'(vecs[v].exp_t));
    end

    // End of block, DONE behaviour, clear
    build_model(abc_blk);
    do_load(abc_blk);
    for (int s = 0; s < 63; s++) do_step(7'(s));
    check("t63 t", 32'(t_idx), 32'd63);
    check("t63 valid", 32'(w_valid), 32'd1);
    check("t63 w", w_out, mw[63]);
    do_step(7'd63);
    check("end done", 32'(done), 32'd1);
    check("end valid", 32'(w_valid), 32'd0);
    check("end t", 32'(t_idx), 32'd63);
    check("end w", w_out, mw[63]);
    repeat (3) do_step(7'd63);
    check("done hold done", 32'(done), 32'd1);
    check("done hold t", 32'(t_idx), 32'd63);
    check("done hold w", w_out, mw[63]);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear done", 32'(done), 32'd0);
    check("clear valid", 32'(w_valid), 32'd0);
    check("clear sync", 32'(sync_err), 32'd0);

    // Mid-block reload with step and clear also asserted
    for (int i = 0; i < 16; i++) b2[511-32*i -: 32] = $urandom;
    do_load(abc_blk);
    for (int s = 0; s < 20; s++) do_step(7'(s));
    check("t20 t", 32'(t_idx), 32'd20);
    load = 1'b1; step = 1'b1; clear = 1'b1; round_idx = 7'd20; block_in = b2;
    tick();
    load = 1'b0; step = 1'b0; clear = 1'b0;
    check("reload t", 32'(t_idx), 32'd0);
    check("reload w", w_out, b2[511:480]);
    check("reload valid", 32'(w_valid), 32'd1);

    // load + clear from DONE goes straight to ACTIVE
    for (int s = 0; s < 64; s++) do_step(7'(s));
    check("b2 done", 32'(done), 32'd1);
    load = 1'b1; clear = 1'b1; step = 1'b1; block_in = abc_blk;
    tick();
    load = 1'b0; clear = 1'b0; step = 1'b0;
    check("done reload valid", 32'(w_valid), 32'd1);
    check("done reload t", 32'(t_idx), 32'd0);
    check("done reload w", w_out, 32'h61626380);

    // Full-run comparison against the reference model with random step gaps
    run_block(abc_blk, "abc");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) b2[511-32*i -: 32] = $urandom;
      run_block(b2, $sformatf("rnd%0d", r));
    end
    check("no sync err", 32'(sync_err), 32'd0);

    // Sync error: sticky across load, cleared only by reset
    do_load(abc_blk);
    do_step(7'd0);
    do_step(7'd2);
    check("sync set", 32'(sync_err), 32'd1);
    do_load(abc_blk);
    check("sync after load", 32'(sync_err), 32'd1);
    check("sync load t", 32'(t_idx), 32'd0);
    do_reset();
    check("sync reset", 32'(sync_err), 32'd0);
    check("reset valid", 32'(w_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset w", w_out, 32'd0);
    check("reset t", 32'(t_idx), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
